// File: rtl/mac_seq_ctrl.sv
// Job sequencer for the multi-lane MAC: issues a counted burst of operand beats,
// tags each beat through the MAC pipeline and accumulates the returned results.
module mac_seq_ctrl #(
    parameter int N_MUL   = 3,
    parameter int MAC_LAT = 7,
    parameter int LEN_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*N_MUL-1:0]  in_wei,
    input  logic [16*N_MUL-1:0]  in_fm,
    output logic [16*N_MUL-1:0]  mac_wei,
    output logic [16*N_MUL-1:0]  mac_fm,
    input  logic [15:0]          mac_res,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          out_data
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e               state_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     issued_q;
    logic [LEN_W-1:0]     retired_q;
    logic [15:0]          acc_q;
    logic [MAC_LAT:0]     tag_q;
    logic [MAC_LAT:0]     tag_d;
    logic                 busy_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [16*N_MUL-1:0]  mac_wei_q;
    logic [16*N_MUL-1:0]  mac_fm_q;

    logic accept;
    logic retire;
    logic last_accept;
    logic last_retire;

    assign accept      = in_valid & in_ready_q;
    assign retire      = tag_q[MAC_LAT];
    assign last_accept = accept && ((issued_q + LEN_W'(1)) == len_q);
    assign last_retire = retire && ((retired_q + LEN_W'(1)) == len_q);
    assign tag_d       = {tag_q[MAC_LAT-1:0], accept};

    // Tag bit k set means the beat accepted k+1 edges ago; the top bit lines up with its mac_res.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            retired_q   <= '0;
            acc_q       <= '0;
            tag_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            mac_wei_q   <= '0;
            mac_fm_q    <= '0;
        end else begin
            tag_q    <= tag_d;
            mac_wei_q <= accept ? in_wei : '0;
            mac_fm_q  <= accept ? in_fm  : '0;
            if (accept) begin
                issued_q <= issued_q + LEN_W'(1);
            end
            if (retire) begin
                acc_q     <= acc_q + mac_res;
                retired_q <= retired_q + LEN_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q    <= 1'b1;
                        len_q     <= len;
                        issued_q  <= '0;
                        retired_q <= '0;
                        acc_q     <= '0;
                        if (len != '0) begin
                            state_q    <= RUN;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (last_accept) begin
                        in_ready_q <= 1'b0;
                        if (last_retire) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (retired_q == len_q) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign mac_wei   = mac_wei_q;
    assign mac_fm    = mac_fm_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed and randomized bench for mac_seq_ctrl with a behavioural Q9 MAC model
// and a job-level reference: expected result is the wrapped sum of the beats sent.
module tb_mac_seq_ctrl;

    localparam int N_MUL   = 3;
    localparam int MAC_LAT = 7;
    localparam int LEN_W   = 16;
    localparam int W       = 16 * N_MUL;

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_wei;
    logic [W-1:0]     in_fm;
    logic [W-1:0]     mac_wei;
    logic [W-1:0]     mac_fm;
    logic [15:0]      mac_res;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;

    int          compareCount = 0;
    int          failCount    = 0;
    int          cycle        = 0;
    int          startEdge    = 0;
    int          lastAccept   = 0;
    logic [15:0] expSum       = '0;
    logic [15:0] macPipe [MAC_LAT];

    mac_seq_ctrl #(.N_MUL(N_MUL), .MAC_LAT(MAC_LAT), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_wei(in_wei), .in_fm(in_fm),
        .mac_wei(mac_wei), .mac_fm(mac_fm), .mac_res(mac_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [15:0] macModel(input logic [W-1:0] w, input logic [W-1:0] f);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < N_MUL; i++) begin
            int a;
            int b;
            int p;
            a = int'($signed(w[16*i +: 16]));
            b = int'($signed(f[16*i +: 16]));
            p = a * b;
            s = s + 16'(p >>> 9);
        end
        return s;
    endfunction

    // The MAC pipeline itself has no reset, so it fills with garbage while rst is high.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAC_LAT; i++) macPipe[i] <= 16'($urandom);
        end else begin
            macPipe[0] <= macModel(mac_wei, mac_fm);
            for (int i = 1; i < MAC_LAT; i++) macPipe[i] <= macPipe[i-1];
        end
    end
    assign mac_res = macPipe[MAC_LAT-1];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gapMode 0: in_valid held high, 1: toggling 1,0,1,..., 2: random
    task automatic applyStimulus(input int n, input int gapMode, input bit fixedData);
        int sent;
        int budget;
        int phase;
        bit acc;
        logic [W-1:0] w;
        logic [W-1:0] f;
        sent   = 0;
        budget = 0;
        phase  = 0;
        start  = 1'b1;
        len    = LEN_W'(n);
        tick();
        startEdge  = cycle;
        start      = 1'b0;
        expSum     = '0;
        lastAccept = startEdge;
        checkOutput("busy after start", busy, 1);
        checkOutput("in_ready after start", in_ready, n != 0);
        if (n == 0) return;
        if (fixedData) begin
            w = {16'd512, 16'd512, 16'd512};
            f = {16'd1536, 16'd1024, 16'd512};
        end else begin
            w = W'({$urandom(), $urandom()});
            f = W'({$urandom(), $urandom()});
        end
        while (sent < n && budget < 10 * n + 50) begin
            if (gapMode == 0) in_valid = 1'b1;
            else if (gapMode == 1) in_valid = (phase % 2 == 0);
            else in_valid = 1'($urandom_range(0, 1));
            in_wei = w;
            in_fm  = f;
            acc    = in_valid && in_ready;
            tick();
            budget++;
            phase++;
            checkOutput("mac_wei drive", mac_wei, acc ? w : '0);
            checkOutput("mac_fm drive", mac_fm, acc ? f : '0);
            if (acc) begin
                expSum     = expSum + macModel(w, f);
                sent++;
                lastAccept = cycle;
                if (!fixedData) begin
                    w = W'({$urandom(), $urandom()});
                    f = W'({$urandom(), $urandom()});
                end
            end
        end
        in_valid = 1'b0;
        checkOutput("beats accepted", sent, n);
        checkOutput("in_ready after last beat", in_ready, 0);
    endtask

    task automatic waitResult();
        int waited;
        waited = 0;
        while (!out_valid && waited < 200) begin
            tick();
            waited++;
        end
        checkOutput("result timeout", out_valid, 1);
        checkOutput("result latency", cycle, lastAccept + MAC_LAT + 2);
        checkOutput("out_data", out_data, expSum);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("out_valid after consume", out_valid, 0);
        checkOutput("busy after consume", busy, 0);
    endtask

    initial begin
        logic [15:0] held;
        int n;
        int gm;
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_wei    = '0;
        in_fm     = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        checkOutput("reset busy", busy, 0);
        checkOutput("reset in_ready", in_ready, 0);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_data", out_data, 0);
        checkOutput("reset mac_wei", mac_wei, 0);
        checkOutput("reset mac_fm", mac_fm, 0);
        rst = 1'b0;
        tick();

        $display("[TB] len=1 Q9 beat");
        applyStimulus(1, 0, 1);
        waitResult();
        checkOutput("len1 latency from start", cycle, startEdge + 10);
        checkOutput("len1 dot", out_data, 3072);

        // Asynchronous reset between clock edges while holding a result.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async rst busy", busy, 0);
        checkOutput("async rst out_valid", out_valid, 0);
        checkOutput("async rst out_data", out_data, 0);
        checkOutput("async rst in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] len=4 back-to-back");
        applyStimulus(4, 0, 1);
        checkOutput("len4 no bubbles", lastAccept, startEdge + 4);
        waitResult();
        checkOutput("len4 dot", out_data, 12288);
        consume();

        $display("[TB] len=32 wrap");
        applyStimulus(32, 0, 1);
        waitResult();
        checkOutput("len32 wrapped dot", out_data, 32768);
        consume();

        $display("[TB] len=3 with gaps");
        applyStimulus(3, 1, 0);
        waitResult();
        consume();

        $display("[TB] DONE hold with start pulse");
        applyStimulus(2, 0, 0);
        waitResult();
        held = out_data;
        for (int i = 0; i < 20; i++) begin
            start = (i == 5);
            len   = 16'd5;
            tick();
            checkOutput("held out_data", out_data, held);
            checkOutput("held out_valid", out_valid, 1);
            checkOutput("held no new job", in_ready, 0);
        end
        start = 1'b0;
        consume();
        applyStimulus(2, 2, 0);
        waitResult();
        consume();

        $display("[TB] len=0");
        applyStimulus(0, 0, 0);
        checkOutput("len0 out_valid", out_valid, 1);
        checkOutput("len0 out_data", out_data, 0);
        checkOutput("len0 in_ready", in_ready, 0);
        consume();

        $display("[TB] abort with beats in flight");
        applyStimulus(3, 0, 0);
        repeat (2) tick();
        #2;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort busy", busy, 0);
        checkOutput("abort out_data", out_data, 0);
        tick();
        applyStimulus(1, 0, 1);
        waitResult();
        checkOutput("post-abort dot", out_data, 3072);
        consume();

        $display("[TB] random jobs");
        for (int j = 0; j < 6; j++) begin
            n  = $urandom_range(1, 6);
            gm = $urandom_range(0, 2);
            applyStimulus(n, gm, 0);
            waitResult();
            repeat ($urandom_range(0, 3)) tick();
            checkOutput("random held out_data", out_data, expSum);
            consume();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
